// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: widths, reset vector, NOP encoding and
// the fetch buffer entry layout.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ILEN_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0

  // One fetched instruction with its address and fall-through address.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-to-decode valid/ready handshake.
//   master (fetch):  drives out_valid, out_instr, out_pc, out_pc_plus4
//   slave  (decode): drives out_ready
interface fetch_stage_if #(
  parameter int unsigned W = 32
);
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_instr;
  logic [W-1:0] out_pc;
  logic [W-1:0] out_pc_plus4;

  modport master (
    output out_valid, out_instr, out_pc, out_pc_plus4,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_instr, out_pc, out_pc_plus4,
    output out_ready
  );
endinterface

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO of fetch entries with push/pop/flush.
//   push, pop, flush : control (flush wins over push and pop)
//   wr_entry         : entry written on push
//   head_c           : entry at the head pointer (combinational read)
//   not_empty_c      : count != 0
//   count            : number of valid entries (0..2)
module fetch_skid_buffer
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head_c,
  output logic         not_empty_c,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         head_ptr;
  logic         tail_ptr;

  // Storage and pointers; 1-bit pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count    <= 2'd0;
    end else if (flush) begin
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        mem[tail_ptr] <= wr_entry;
        tail_ptr      <= ~tail_ptr;
      end
      if (pop) begin
        head_ptr <= ~head_ptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_c      = mem[head_ptr];
  assign not_empty_c = (count != 2'd0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads the asynchronous instruction
// memory, and buffers {pc, instr, pc+4} for decode in a 2-entry FIFO so decode
// stalls never reach the PC combinationally. Redirects reload the PC and
// flush the buffer.
//   clk, rst_n            : clock, async active-low reset
//   imem_addr / imem_rd   : instruction memory address (= pc) and read data
//   redirect_i / _pc_i    : load new PC and flush buffer
//   dec (master)          : out_valid/out_ready/out_instr/out_pc/out_pc_plus4
//   misalign_o            : pulse when the accepted redirect target had [1:0] != 0
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned   n        = XLEN,
  parameter logic [n-1:0]  RESET_PC = RESET_VECTOR,
  parameter int unsigned   DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [n-1:0]  imem_addr,
  input  logic [n-1:0]  imem_rd,
  input  logic          redirect_i,
  input  logic [n-1:0]  redirect_pc_i,
  fetch_stage_if.master dec,
  output logic          misalign_o
);

  logic [n-1:0] pc;
  logic [n-1:0] pc_plus4_c;
  logic         push_c;
  logic         pop_c;
  logic         not_empty_c;
  logic [1:0]   count;
  fetch_entry_t wr_entry_c;
  fetch_entry_t head_c;

  assign pc_plus4_c = pc + n'(ILEN_BYTES);
  assign push_c     = !redirect_i && (count != 2'(DEPTH));
  assign pop_c      = not_empty_c && dec.out_ready && !redirect_i;
  assign wr_entry_c = '{pc: pc, instr: imem_rd, pc_plus4: pc_plus4_c};

  // PC register and misalign pulse; redirect has priority over sequential fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
      if (redirect_i) begin
        pc <= {redirect_pc_i[n-1:2], 2'b00};
      end else if (push_c) begin
        pc <= pc_plus4_c;
      end
    end
  end

  fetch_skid_buffer u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push_c),
    .pop         (pop_c),
    .flush       (redirect_i),
    .wr_entry    (wr_entry_c),
    .head_c      (head_c),
    .not_empty_c (not_empty_c),
    .count       (count)
  );

  assign imem_addr        = {pc[n-1:2], 2'b00};
  assign dec.out_valid    = not_empty_c;
  assign dec.out_instr    = not_empty_c ? head_c.instr : NOP_INSTR;
  assign dec.out_pc       = head_c.pc;
  assign dec.out_pc_plus4 = head_c.pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Instruction memory word at byte address a is
// 32'hC0DE_0000 | a[9:2], so expected instructions are hand-written constants.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        misalign_o;

  int unsigned checks;
  int unsigned failures;

  fetch_stage_if #(.W(32)) dec_if ();

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rd       (imem_rd),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .dec           (dec_if),
    .misalign_o    (misalign_o)
  );

  assign imem_rd = 32'hC0DE_0000 | {24'h0, imem_addr[9:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] instr, input logic [31:0] pc);
    check({tag, ".valid"}, 32'(dec_if.out_valid), 32'd1);
    check({tag, ".instr"}, dec_if.out_instr, instr);
    check({tag, ".pc"}, dec_if.out_pc, pc);
    check({tag, ".pc4"}, dec_if.out_pc_plus4, pc + 32'd4);
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_i    = 1'b1;
    redirect_pc_i = target;
    step();
    redirect_i    = 1'b0;
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    rst_n            = 1'b0;
    redirect_i       = 1'b0;
    redirect_pc_i    = 32'h0;
    dec_if.out_ready = 1'b1;
    #12;
    check("rst.valid", 32'(dec_if.out_valid), 32'd0);
    check("rst.instr", dec_if.out_instr, 32'h0000_0013);
    check("rst.pc", dec_if.out_pc, 32'h0);
    check("rst.pc4", dec_if.out_pc_plus4, 32'h0);
    check("rst.addr", imem_addr, 32'h0);
    check("rst.mis", 32'(misalign_o), 32'd0);

    // Streaming from reset.
    @(negedge clk);
    rst_n = 1'b1;
    step();
    expect_head("s0", 32'hC0DE_0000, 32'h0);
    step();
    expect_head("s1", 32'hC0DE_0001, 32'h4);
    step();
    expect_head("s2", 32'hC0DE_0002, 32'h8);
    step();
    expect_head("s3", 32'hC0DE_0003, 32'hC);

    // Restart at 0, then stall decode for 5 cycles once A is valid.
    redirect(32'h0);
    dec_if.out_ready = 1'b0;
    check("rd0.valid", 32'(dec_if.out_valid), 32'd0);
    check("rd0.addr", imem_addr, 32'h0);
    step();
    expect_head("hA", 32'hC0DE_0000, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("hold%0d.instr", i), dec_if.out_instr, 32'hC0DE_0000);
      check($sformatf("hold%0d.addr", i), imem_addr, 32'h8);
    end
    dec_if.out_ready = 1'b1;
    step();
    expect_head("relB", 32'hC0DE_0001, 32'h4);
    step();
    expect_head("relC", 32'hC0DE_0002, 32'h8);
    step();
    expect_head("relD", 32'hC0DE_0003, 32'hC);

    // Fill to 2 entries, then redirect with decode ready.
    dec_if.out_ready = 1'b0;
    step();
    check("fill.addr", imem_addr, 32'h14);
    dec_if.out_ready = 1'b1;
    redirect(32'h40);
    check("r40.valid", 32'(dec_if.out_valid), 32'd0);
    check("r40.instr", dec_if.out_instr, 32'h0000_0013);
    check("r40.addr", imem_addr, 32'h40);
    step();
    expect_head("r40.head", 32'hC0DE_0010, 32'h40);

    // Misaligned target.
    redirect(32'h46);
    check("r46.mis", 32'(misalign_o), 32'd1);
    check("r46.addr", imem_addr, 32'h44);
    step();
    check("r46.mis_off", 32'(misalign_o), 32'd0);
    expect_head("r46.head", 32'hC0DE_0011, 32'h44);

    // Back-to-back redirects: only the last target is fetched.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h80;
    step();
    check("b2b.mis", 32'(misalign_o), 32'd0);
    redirect(32'h100);
    check("b2b.valid", 32'(dec_if.out_valid), 32'd0);
    check("b2b.addr", imem_addr, 32'h100);
    step();
    expect_head("b2b.head", 32'hC0DE_0040, 32'h100);

    // PC wrap-around at the top of the address space.
    redirect(32'hFFFF_FFFC);
    step();
    check("wrap.pc", dec_if.out_pc, 32'hFFFF_FFFC);
    check("wrap.pc4", dec_if.out_pc_plus4, 32'h0);
    check("wrap.instr", dec_if.out_instr, 32'hC0DE_00FF);
    step();
    expect_head("wrap.next", 32'hC0DE_0000, 32'h0);

    // Asynchronous reset mid-stream with a full buffer.
    dec_if.out_ready = 1'b0;
    step();
    check("full.addr", imem_addr, 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(dec_if.out_valid), 32'd0);
    check("arst.instr", dec_if.out_instr, 32'h0000_0013);
    check("arst.addr", imem_addr, 32'h0);
    @(negedge clk);
    rst_n            = 1'b1;
    dec_if.out_ready = 1'b1;
    step();
    expect_head("arst.head", 32'hC0DE_0000, 32'h0);
    step();
    expect_head("arst.next", 32'hC0DE_0001, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
